// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the latency-modelling data memory
package mem_resp_pkg;

   localparam int WORD_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Counter preload: the acceptance cycle itself accounts for one cycle of latency.
   function automatic logic [CNT_W-1:0] latency_load(input int latency);
      return CNT_W'(latency - 1);
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - single-port word array, synchronous write, combinational read
module mem_resp_array
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

   // Write port: contents survive reset, only an explicit write changes them.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_latency_responder.sv
// rtl/mem_latency_responder.sv - multi-cycle data memory responder for the Rd/Wr/Stall/Done handshake
module mem_latency_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] Addr,
   input  logic [WORD_W-1:0] DataIn,
   input  logic              Rd,
   input  logic              Wr,
   output logic [WORD_W-1:0] DataOut,
   output logic              Done,
   output logic              Stall,
   output logic              err
);

   localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   op_t                     op_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [WORD_W-1:0]       data_q;

   logic                    req;
   logic                    illegal;
   logic                    accept;
   logic                    mem_we;
   logic [WORD_W-1:0]       mem_rdata;
   logic                    unused_addr_hi;

   assign req     = Rd | Wr;
   assign illegal = (Rd & Wr) | Addr[0];
   assign accept  = (state_q == IDLE) && req && !illegal;

   // Address bits above the array depth alias onto the array and carry no meaning.
   assign unused_addr_hi = ^Addr[WORD_W-1:DEPTH_LOG2+1];

   // State and countdown register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture: the requester may wander during BUSY, so work from latched copies.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_RD;
         idx_q  <= '0;
         data_q <= '0;
      end else if (accept) begin
         op_q   <= Wr ? OP_WR : OP_RD;
         idx_q  <= Addr[DEPTH_LOG2:1];
         data_q <= DataIn;
      end
   end

   // Next-state: accept legal requests from IDLE, count down in BUSY, return on the final cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: illegal requests complete immediately with err; legal ones stall until the count expires.
   always_comb begin
      Done    = 1'b0;
      Stall   = 1'b0;
      err     = 1'b0;
      mem_we  = 1'b0;
      DataOut = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  err  = 1'b1;
                  Done = 1'b1;
               end else begin
                  Stall = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               Stall = 1'b1;
            end else begin
               Done = 1'b1;
               if (op_q == OP_RD) begin
                  DataOut = mem_rdata;
               end else begin
                  // A reset landing on the commit edge must not let the write through.
                  mem_we = !rst;
               end
            end
         end
         default: begin
            Done = 1'b0;
         end
      endcase
   end

   mem_resp_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (idx_q),
      .wdata (data_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mem_latency_responder.sv
// tb/tb_mem_latency_responder.sv - directed bench for mem_latency_responder at LATENCY 4 and 1
module tb_mem_latency_responder;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, din, dout;
   logic        rd, wr, done, stall, err;
   logic [15:0] addr1, din1, dout1;
   logic        rd1, wr1, done1, stall1, err1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic        corrupt;
      logic        exp_err;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t vecs [12];

   always #5 clk = ~clk;

   mem_latency_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
      .DataOut(dout), .Done(done), .Stall(stall), .err(err)
   );

   mem_latency_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .Addr(addr1), .DataIn(din1), .Rd(rd1), .Wr(wr1),
      .DataOut(dout1), .Done(done1), .Stall(stall1), .err(err1)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request on the LATENCY=4 instance; returns just after the Done-cycle checks.
   task automatic access(input vec_t v, input string tag);
      @(negedge clk);
      rd = v.rd; wr = v.wr; addr = v.addr; din = v.din;
      #1;
      if (v.exp_err) begin
         chk({tag, " err"},   {15'd0, err},   16'd1);
         chk({tag, " done"},  {15'd0, done},  16'd1);
         chk({tag, " stall"}, {15'd0, stall}, 16'd0);
         chk({tag, " dout"},  dout,           16'd0);
      end else begin
         for (int c = 0; c < LAT; c++) begin
            chk($sformatf("%s stall c%0d", tag, c), {15'd0, stall}, 16'd1);
            chk($sformatf("%s done c%0d", tag, c),  {15'd0, done},  16'd0);
            chk($sformatf("%s dout c%0d", tag, c),  dout,           16'd0);
            @(negedge clk);
            if (v.corrupt) din = 16'hFFFF;
            #1;
         end
         chk({tag, " done"},  {15'd0, done},  16'd1);
         chk({tag, " stall"}, {15'd0, stall}, 16'd0);
         chk({tag, " err"},   {15'd0, err},   16'd0);
         chk({tag, " dout"},  dout,           v.exp_dout);
      end
   endtask

   // One request on the LATENCY=1 instance.
   task automatic access1(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp, input string tag);
      @(negedge clk);
      rd1 = r; wr1 = w; addr1 = a; din1 = d;
      #1;
      chk({tag, " accept stall"}, {15'd0, stall1}, 16'd1);
      chk({tag, " accept done"},  {15'd0, done1},  16'd0);
      @(negedge clk);
      #1;
      chk({tag, " done"},  {15'd0, done1},  16'd1);
      chk({tag, " stall"}, {15'd0, stall1}, 16'd0);
      chk({tag, " dout"},  dout1,           exp);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
      vecs[2]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1, 16'h0000};
      vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
      vecs[4]  = '{1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0, 1'b0, 16'h0000};
      vecs[5]  = '{1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 1'b1, 16'h0021, 16'h0000, 1'b0, 1'b1, 16'h0000};
      vecs[7]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h5A5A};
      vecs[8]  = '{1'b0, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h1234};
      vecs[10] = '{1'b0, 1'b1, 16'h07FE, 16'hC0DE, 1'b0, 1'b0, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b0, 1'b0, 16'hC0DE};

      rst = 1'b1;
      rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset done",  {15'd0, done},  16'd0);
      chk("reset stall", {15'd0, stall}, 16'd0);
      chk("reset err",   {15'd0, err},   16'd0);
      chk("reset dout",  dout,           16'd0);
      chk("reset done1", {15'd0, done1}, 16'd0);

      for (int i = 0; i < 12; i++) begin
         access(vecs[i], $sformatf("v%0d", i));
      end

      // Reset two cycles into a write: the write is dropped.
      access('{1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0, 1'b0, 16'h0000}, "rst pre");
      @(negedge clk);
      rd = 1'b0; wr = 1'b1; addr = 16'h0040; din = 16'hAAAA;
      #1;
      chk("rst accept stall", {15'd0, stall}, 16'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; wr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post rst done",  {15'd0, done},  16'd0);
      chk("post rst stall", {15'd0, stall}, 16'd0);
      chk("post rst err",   {15'd0, err},   16'd0);
      chk("post rst dout",  dout,           16'd0);
      access('{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h1111}, "rst read");
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;

      // LATENCY=1: completion one cycle after each acceptance, back-to-back.
      access1(1'b0, 1'b1, 16'h0000, 16'h0F0F, 16'h0000, "l1 w0");
      access1(1'b0, 1'b1, 16'h0002, 16'hF0F0, 16'h0000, "l1 w2");
      access1(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, "l1 r0");
      access1(1'b1, 1'b0, 16'h0002, 16'h0000, 16'hF0F0, "l1 r2");
      @(negedge clk);
      rd1 = 1'b0; wr1 = 1'b0;
      #1;
      chk("l1 idle done", {15'd0, done1}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
